// File: rtl/poly_drv_pkg.sv
// Shared types and constants for the polynomial-evaluator initiator:
// FSM encoding, Q24.8 / Q120.8 widths, saturation bounds, timeout width.
package poly_drv_pkg;

    // Driver FSM states; the encoding is also visible on dbg_state.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    // Fixed-point geometry of the narrow (stream) and wide (evaluator) formats.
    localparam int FRAC_BITS = 8;
    localparam int INT_BITS  = 24;
    localparam int Q_W       = INT_BITS + FRAC_BITS;   // Q24.8 word
    localparam int Y_W       = 128;                    // Q120.8 word

    // Saturation bounds of signed Q24.8.
    localparam logic [Q_W-1:0] Q24_8_MAX = 32'h7FFF_FFFF;
    localparam logic [Q_W-1:0] Q24_8_MIN = 32'h8000_0000;

    // Width of the done-wait timeout counter (TIMEOUT_CYCLES must fit).
    localparam int TMO_W = 8;

    // One entry of the output register.
    typedef struct packed {
        logic           err;   // evaluator never answered
        logic           sat;   // wide result was clipped
        logic [Q_W-1:0] y;     // Q24.8 result
    } result_t;

    // True when the wide value is representable in Q24.8: every bit from the
    // Q24.8 sign position upward is a copy of the same sign.
    function automatic logic fits_q24_8(input logic [Y_W-1:0] y);
        return (&y[Y_W-1:Q_W-1]) | ~(|y[Y_W-1:Q_W-1]);
    endfunction

endpackage

// File: rtl/poly_func_driver_sat.sv
// Combinational narrowing of a signed Q120.8 value to signed Q24.8 with
// clipping to the Q24.8 extremes and a flag telling whether clipping happened.
module q128_to_q32_sat
    import poly_drv_pkg::*;
(
    input  logic [Y_W-1:0] y,
    output logic [Q_W-1:0] q,
    output logic           sat
);

    // Pass the low word through when it fits, otherwise clip toward the sign.
    always_comb begin
        q   = y[Q_W-1:0];
        sat = 1'b0;
        if (!fits_q24_8(y)) begin
            sat = 1'b1;
            q   = y[Y_W-1] ? Q24_8_MIN : Q24_8_MAX;
        end
    end

endmodule

// File: rtl/poly_func_driver.sv
// Initiator-side controller for the fixed-point polynomial evaluator.
// Takes Q24.8 samples from a valid/ready stream, runs one level-held
// start_func/func_done transaction per sample, narrows the Q120.8 result to
// saturated Q24.8 and offers it on a one-entry valid/ready output stream.
//
// Stream handshakes (both s_* and m_*): a transfer happens on a rising clk
// edge where valid and ready are both 1. A source keeps valid and its data
// stable until that transfer; ready may change freely. Here m_valid, m_y,
// m_sat and m_err are held until m_ready, and s_ready never depends on s_valid.
//
// TIMEOUT_CYCLES must lie in 1..255 so it fits the 8-bit wait counter.
module poly_func_driver
    import poly_drv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
)
(
    input  logic             clk,
    input  logic             rst,
    // sample input stream
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [Q_W-1:0]   s_x,
    // evaluator handshake
    output logic             start_func,
    output logic [Q_W-1:0]   x_in,
    input  logic [Y_W-1:0]   y_out,
    input  logic             func_done,
    // result output stream
    output logic             m_valid,
    input  logic             m_ready,
    output logic [Q_W-1:0]   m_y,
    output logic             m_sat,
    output logic             m_err,
    // status
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Last count value before the wait is declared lost.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    result_t          out_q;

    logic             s_fire;
    logic             out_free;
    logic             cap_done;
    logic             cap_tmo;
    logic [Q_W-1:0]   sat_y;
    logic             sat_flag;

    // Narrowing of the evaluator result; y_out is stable while func_done is
    // high, so the capture can happen in any cycle of that window.
    q128_to_q32_sat u_sat (
        .y   (y_out),
        .q   (sat_y),
        .sat (sat_flag)
    );

    // Event decode shared by the FSM and the datapath registers.
    always_comb begin
        s_fire   = s_valid & s_ready;
        // The single output entry can take a new result when it is empty or
        // is being drained this very cycle, so there is no bubble.
        out_free = ~m_valid | m_ready;
        cap_done = (state == WAIT_DONE) & func_done & out_free;
        // A stalled-but-done result never times out: the timeout path needs
        // func_done low. It also waits for a free entry so it never overwrites
        // a pending result.
        cap_tmo  = (state == WAIT_DONE) & ~func_done & (tmo_cnt == TMO_LAST) & out_free;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (s_fire) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (cap_done || cap_tmo) state_nxt = RELEASE;
            RELEASE:   if (!func_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // FSM outputs. s_ready also waits for func_done low so a done left over
    // from before a reset cannot be mistaken for the next sample's answer.
    always_comb begin
        start_func = (state == ISSUE) || (state == WAIT_DONE);
        busy       = (state != IDLE);
        s_ready    = (state == IDLE) && !func_done && !rst;
        dbg_state  = state;
    end

    // Sample register feeding the evaluator; loaded on the input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_in <= '0;
        end else if (s_fire) begin
            x_in <= s_x;
        end
    end

    // Done-wait counter: cleared in ISSUE so it starts at zero on entry to
    // WAIT_DONE, counts only while func_done is low, and parks at its limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_DONE && !func_done && tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // One-entry output register: loaded on capture or timeout, emptied by
    // m_ready, contents frozen while valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            out_q     <= '0;
        end else if (cap_done) begin
            m_valid   <= 1'b1;
            out_q.err <= 1'b0;
            out_q.sat <= sat_flag;
            out_q.y   <= sat_y;
        end else if (cap_tmo) begin
            m_valid   <= 1'b1;
            out_q.err <= 1'b1;
            out_q.sat <= 1'b0;
            out_q.y   <= '0;
        end else if (m_ready) begin
            m_valid   <= 1'b0;
        end
    end

    // Output stream fields come straight from the entry.
    always_comb begin
        m_y   = out_q.y;
        m_sat = out_q.sat;
        m_err = out_q.err;
    end

endmodule

// File: tb/tb_poly_func_driver.sv
// Directed bench for poly_func_driver with a behavioural cosine evaluator.
module tb_poly_func_driver;

    localparam logic signed [127:0] Q_HI = 128'sh0000_0000_0000_0000_0000_0000_7FFF_FFFF;
    localparam logic signed [127:0] Q_LO = 128'shFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_8000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_x = '0;
    logic         start_func;
    logic [31:0]  x_in;
    logic [127:0] y_out = '0;
    logic         func_done = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [31:0]  m_y;
    logic         m_sat;
    logic         m_err;
    logic         busy;
    logic [1:0]   dbg_state;

    int           vec_cnt = 0;
    int           miscompares = 0;
    int           cyc = 0;
    logic [33:0]  exp_q[$];
    logic [33:0]  mon_exp;

    logic         rand_ready = 1'b0;
    logic         m_ready_req = 1'b0;
    logic [1:0]   ev_mode = 2'd0;     // 0 cosine, 1 fixed value, 2 never done
    logic [127:0] ev_fixed = '0;
    logic         ev_hold = 1'b0;     // keep func_done high regardless of start
    int           ev_cnt = 0;

    logic [127:0] fix_y [7] = '{
        128'h0000_0000_0000_0000_0000_0001_0000_0000,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00_0000_0000,
        128'h0000_0000_0000_0000_0000_0000_7FFF_FFFF,
        128'h0000_0000_0000_0000_0000_0000_8000_0000,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_7FFF_FFFF,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_8000_0000
    };
    logic [33:0] fix_e [7] = '{
        {2'b01, 32'h7FFF_FFFF},
        {2'b01, 32'h8000_0000},
        {2'b00, 32'h7FFF_FFFF},
        {2'b01, 32'h7FFF_FFFF},
        {2'b00, 32'hFFFF_FFFF},
        {2'b01, 32'h8000_0000},
        {2'b00, 32'h8000_0000}
    };

    poly_func_driver #(.TIMEOUT_CYCLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_x        (s_x),
        .start_func (start_func),
        .x_in       (x_in),
        .y_out      (y_out),
        .func_done  (func_done),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_y        (m_y),
        .m_sat      (m_sat),
        .m_err      (m_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // ---------------- reference models ----------------
    // Cosine polynomial, Horner form, Q.8 coefficients 256, 0, -128, 0, 10.
    function automatic logic [127:0] cos_poly(input logic [31:0] x);
        logic signed [127:0] xs;
        logic signed [127:0] acc;
        xs  = {{96{x[31]}}, x};
        acc = 128'sd10;
        acc = (acc * xs) >>> 8;
        acc = ((acc * xs) >>> 8) - 128'sd128;
        acc = (acc * xs) >>> 8;
        acc = ((acc * xs) >>> 8) + 128'sd256;
        return acc;
    endfunction

    // Expected {err, sat, y} for a wide evaluator value.
    function automatic logic [33:0] ref_result(input logic [127:0] y);
        logic signed [127:0] v;
        v = y;
        if (v > Q_HI) return {2'b01, 32'h7FFF_FFFF};
        if (v < Q_LO) return {2'b01, 32'h8000_0000};
        return {2'b00, y[31:0]};
    endfunction

    // Evaluator: done sampled high 8 edges after start first seen, held until start drops.
    always @(posedge clk) begin
        if (!start_func && !ev_hold) begin
            func_done <= 1'b0;
            ev_cnt    <= 0;
        end else if (start_func && !func_done && ev_mode != 2'd2) begin
            if (ev_cnt == 7) begin
                func_done <= 1'b1;
                y_out     <= (ev_mode == 2'd1) ? ev_fixed : cos_poly(x_in);
            end else begin
                ev_cnt <= ev_cnt + 1;
            end
        end
    end

    // Output-side ready driver.
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : m_ready_req;
    end

    // ---------------- checking ----------------
    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every output transfer is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_vec("unexpected_result", {m_err, m_sat, m_y}, 128'hDEAD);
            end else begin
                mon_exp = exp_q.pop_front();
                check_vec("result", {m_err, m_sat, m_y}, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, output int e);
        logic ok;
        ok = 1'b0;
        e  = 0;
        tick();
        s_x     = x;
        s_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                e  = cyc;
                ok = 1'b1;
            end
        end
        s_valid = 1'b0;
        if (!ok) check_vec("send_accept", 0, 1);
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int i = 0; i < 200 && c < 0; i++) begin
            @(negedge clk);
            if (m_valid) c = cyc;
        end
        if (c < 0) check_vec("wait_valid", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check_vec("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string pfx);
        check_vec({pfx, "_s_ready"}, s_ready, 0);
        check_vec({pfx, "_start"}, start_func, 0);
        check_vec({pfx, "_x_in"}, x_in, 0);
        check_vec({pfx, "_m_valid"}, m_valid, 0);
        check_vec({pfx, "_m_y"}, m_y, 0);
        check_vec({pfx, "_m_sat"}, m_sat, 0);
        check_vec({pfx, "_m_err"}, m_err, 0);
        check_vec({pfx, "_busy"}, busy, 0);
        check_vec({pfx, "_state"}, dbg_state, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e, e2, c, bad;
        logic ok;
        logic [31:0] x;
        logic [127:0] y;

        // Reset values.
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        tick();
        rst = 1'b0;

        // Cosine x = 1.0: latency and value.
        send(32'h0000_0100, e);
        exp_q.push_back({2'b00, 32'h0000_008A});
        @(negedge clk);
        check_vec("start_t1", start_func, 1);
        check_vec("x_in_t1", x_in, 32'h0000_0100);
        wait_valid(c);
        check_vec("valid_lat", 128'(c - e), 9);
        check_vec("start_fall", start_func, 0);
        check_vec("cos1_m_y", m_y, 32'h0000_008A);
        m_ready_req = 1'b1;
        c = -1;
        for (int i = 0; i < 50 && c < 0; i++) begin
            @(negedge clk);
            if (s_ready) c = cyc;
        end
        check_vec("idle_reentry", 128'(c - e), 11);

        // Cosine x = 0.
        send(32'h0, e);
        exp_q.push_back({2'b00, 32'h0000_0100});
        drain();

        // Saturation boundaries through a fixed-value evaluator.
        ev_mode = 2'd1;
        for (int i = 0; i < 7; i++) begin
            ev_fixed = fix_y[i];
            send(32'h0000_0040, e);
            exp_q.push_back(fix_e[i]);
            drain();
        end
        ev_mode = 2'd0;

        // Backpressure: two samples with m_ready low for 40+ cycles.
        m_ready_req = 1'b0;
        tick();
        send(32'h0000_0200, e);
        exp_q.push_back({2'b00, 32'hFFFF_FFA0});
        send(32'hFFFF_FF00, e2);
        exp_q.push_back({2'b00, 32'h0000_008A});
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i >= 10 && !(start_func && func_done && dbg_state == 2'd2 && m_valid)) bad++;
        end
        check_vec("bp_hold", bad, 0);
        check_vec("bp_first_held", m_y, 32'hFFFF_FFA0);
        m_ready_req = 1'b1;
        drain();

        // Timeout: evaluator never answers.
        ev_mode = 2'd2;
        send(32'h0000_0300, e);
        exp_q.push_back({2'b10, 32'h0});
        wait_valid(c);
        check_vec("tmo_lat", 128'(c - e), 33);
        check_vec("tmo_err", m_err, 1);
        check_vec("tmo_start_drop", start_func, 0);
        ev_mode = 2'd0;
        drain();
        send(32'h0000_0100, e);
        exp_q.push_back({2'b00, 32'h0000_008A});
        drain();

        // Reset during WAIT_DONE with func_done held high.
        m_ready_req = 1'b0;
        tick();
        send(32'h0000_0100, e);
        send(32'h0000_0000, e2);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (func_done && dbg_state == 2'd2) ok = 1'b1;
        end
        check_vec("rst_reach_wait", ok, 1);
        ev_hold = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        repeat (2) tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_ready || m_valid) bad++;
        end
        check_vec("midrst_gated", bad, 0);
        tick();
        ev_hold = 1'b0;
        tick();
        @(negedge clk);
        check_vec("midrst_ready_back", s_ready, 1);
        check_vec("midrst_no_valid", m_valid, 0);
        m_ready_req = 1'b1;

        // Random stream with random m_ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = (i % 2 == 0) ? (32'($urandom_range(0, 4095)) - 32'd2048) : 32'($urandom);
            y = cos_poly(x);
            exp_q.push_back(ref_result(y));
            send(x, e);
        end
        drain();
        rand_ready = 1'b0;
        m_ready_req = 1'b1;

        repeat (3) tick();
        @(negedge clk);
        check_vec("final_m_valid", m_valid, 0);
        check_vec("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/poly_func_driver.md
# poly_func_driver

Initiator-side controller for the fixed-point polynomial evaluator. It accepts Q24.8 samples on a valid/ready input stream and drives the evaluator's level-held `start_func`/`func_done` handshake, one sample per transaction. It narrows the evaluator's 128-bit Q120.8 result to saturated Q24.8 and presents it on a valid/ready output stream. It sits between the sample source and the evaluator, so the evaluator can be used in a streaming datapath.

## Interface
- `TIMEOUT_CYCLES`, default 32: maximum cycles to wait for `func_done` while `start_func` is held; 1 to 255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: driver can accept a sample.
- `s_x` in 32: input sample, signed Q24.8.
- `start_func` out 1: evaluator start, level-held.
- `x_in` out 32: sample to evaluator, signed Q24.8.
- `y_out` in 128: evaluator result, signed Q120.8.
- `func_done` in 1: evaluator done, level.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result accepted.
- `m_y` out 32: result, signed Q24.8, saturated.
- `m_sat` out 1: this result was saturated.
- `m_err` out 1: this result timed out (`m_y` = 0).
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on an input handshake (`s_valid & s_ready`). The sample is registered to `x_in`.
  - ISSUE: `start_func` = 1. Next state is WAIT_DONE.
  - WAIT_DONE: `start_func` stays 1.
    - If `func_done` = 1 and the output register is empty (or drains this cycle): capture the saturated `y_out`, then go to RELEASE.
    - If `func_done` = 0 and the timeout counter reaches `TIMEOUT_CYCLES`: load the output with `m_y` = 0, `m_err` = 1, `m_sat` = 0, then go to RELEASE.
  - RELEASE: `start_func` = 0. Go to IDLE once `func_done` is sampled 0.
- `s_ready` = (state == IDLE) & !`func_done`. This gating protects against a stale done after reset.
- Output register: one entry.
  - `m_valid` stays high until `m_ready`; `m_y`, `m_sat`, `m_err` hold stable while `m_valid` = 1.
  - A new sample may be accepted while the previous result is still pending.
  - Backpressure: if the output is full when `func_done` rises, the FSM stays in WAIT_DONE with `start_func` held. The evaluator then holds `y_out` stable.
- Timeout counter:
  - Cleared on entry to WAIT_DONE.
  - Increments only while `func_done` = 0.
  - A result stalled by backpressure never times out.
- Saturation of `y_out` to Q24.8:
  - If bits [127:31] are all equal: `m_y` = `y_out`[31:0], `m_sat` = 0.
  - Otherwise: `m_y` = 0x7FFFFFFF when `y_out`[127] = 0, or 0x80000000 when `y_out`[127] = 1; `m_sat` = 1.
- Results are emitted strictly in input order, one per accepted sample.

## Timing
- Reset values: `s_ready` = 0 during reset, `start_func` = 0, `x_in` = 0, `m_valid` = 0, `m_y` = 0, `m_sat` = 0, `m_err` = 0, `busy` = 0, FSM = IDLE, counter = 0.
- Reset mid-operation: state is discarded and no partial result is emitted. After reset, `s_ready` stays 0 until `func_done` = 0.
- Input handshake in cycle T: `x_in` valid and `start_func` = 1 from T+1.
- With the nominal evaluator, `func_done` is sampled high at T+9.
- `m_valid` = 1 in the cycle after `func_done` is captured (T+10 with the output free).
- `start_func` falls in the same cycle that the result is captured into the output register.
- IDLE is re-entered one cycle after `func_done` is sampled low. `s_ready` rises in that cycle.
- Throughput with the nominal evaluator: one sample per about 12 cycles.
- Simultaneous events:
  - `m_ready` in the capture cycle frees the register for the new result; there is no bubble.
  - `s_valid` in the IDLE entry cycle is accepted.

## Structure
- Package `poly_drv_pkg`:
  - state enum (IDLE, ISSUE, WAIT_DONE, RELEASE);
  - `FRAC_BITS` = 8;
  - `Q24_8_MAX` = 32'h7FFFFFFF and `Q24_8_MIN` = 32'h80000000;
  - timeout counter width of 8.
- Sub-module `q128_to_q32_sat`: combinational Q120.8 → Q24.8 saturator with `sat` flag output. It is instantiated once.

## Test plan
- Cosine evaluator (coefficients 1, 0, −0.5, 0, 0.0390625):
  - `s_x` = 0x00000100 → `m_y` = 0x0000008A, `m_sat` = 0, `m_err` = 0, `m_valid` at T+10.
  - `s_x` = 0 → `m_y` = 0x00000100.
- Evaluator model returns `y_out` = 128'h1_0000_0000 → `m_y` = 0x7FFFFFFF, `m_sat` = 1. Model returns `y_out` = −2^40 → `m_y` = 0x80000000, `m_sat` = 1.
- Two samples with `m_ready` low for 40 cycles: the second transaction holds `start_func` with `func_done` high and no timeout. Both results emerge in order once `m_ready` rises.
- Model never asserts `func_done`: after 32 cycles in WAIT_DONE, `m_valid` = 1 with `m_err` = 1 and `m_y` = 0. `start_func` drops and the next sample proceeds normally.
- Assert `rst` during WAIT_DONE while the model holds `func_done` = 1:
  - all outputs go to their reset values immediately;
  - `s_ready` stays 0 until the model drops `func_done`;
  - no spurious `m_valid`.
- Back-to-back stream of 8 random Q24.8 samples with random `m_ready`: every output matches the reference polynomial model bit-exactly, with saturation applied.
